data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

Responder end of the core's data-memory interface: decodes `mem_ren`/`mem_wen`/`mem_addr`/`mem_dout` from the MEM stage and returns `mem_din`. It serves a word-addressed data RAM and a small MMIO page with LED/switch registers and an interval timer. The timer raises the interrupt request consumed by the interrupt-capable pipeline. It sits beside the core at top level, replacing a bare data RAM.

## Interface
- `ADDR_WIDTH`, 10: RAM word-address bits (RAM = 2^ADDR_WIDTH words).
- `LED_WIDTH`, 16: LED register width.
- `SW_WIDTH`, 16: switch input width.
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous, active-low (asserted when 0).
- `mem_ren` input 1: read enable from the core.
- `mem_wen` input 1: write enable from the core.
- `mem_addr` input 32: byte address. Bits [1:0] are ignored.
- `mem_dout` input 32: write data from the core.
- `mem_din` output 32: read data to the core.
- `sw` input SW_WIDTH: asynchronous switch inputs.
- `led` output LED_WIDTH: LED register.
- `irq` output 1: timer interrupt request, registered.

## Operation
- **Decode**
  - RAM when `mem_addr[31:ADDR_WIDTH+2]` = 0.
  - MMIO when `mem_addr[31:8]` = 0xFFFFFF.
  - Anything else is unmapped: reads return 0, writes are ignored.
- **MMIO registers** (offset = `mem_addr[7:0]`)
  - 0x00 LED: RW.
  - 0x04 SW: RO. Value is `sw` after a two-flop synchronizer, zero-extended.
  - 0x10 TCTRL: RW. bit0 enable, bit1 auto-reload, bit2 irq-enable. Other bits read 0.
  - 0x14 TCMP: RW.
  - 0x18 TCNT: RW.
  - 0x1C TSTAT: bit0 pending. Writing 1 clears it; writing 0 has no effect.
  - Other offsets read 0 and ignore writes.
- **Timer**
  - While enable=1, TCNT increments by 1 every cycle, wrapping modulo 2^32.
  - On a cycle where enable=1 and TCNT == TCMP:
    - pending is set.
    - If auto-reload=1, TCNT goes to 0 next cycle and counting continues.
    - If auto-reload=0, enable is cleared and TCNT holds.
- **irq**: registered copy of (pending & irq-enable), so it lags by 1 cycle.
- **Simultaneous events**
  - Hardware set of pending and a software W1C in the same cycle: pending ends at 1.
  - Software write to TCNT in a match/increment cycle: the written value wins, but pending is still set by the match.
  - Software write to TCTRL in a match cycle: the written value wins.
- **Both `mem_ren` and `mem_wen` high**: the write is performed and `mem_din` returns the pre-write value.
- `mem_din` = 0 whenever `mem_ren` = 0.

## Timing
- Reads are combinational: `mem_din` is valid in the same cycle as `mem_ren`/`mem_addr`. This matches the core's single-cycle MEM stage.
- Writes (RAM and MMIO) commit on the rising edge of `clk` while `mem_wen`=1.
- Reset values:
  - LED = 0, TCTRL = 0, TCMP = 0xFFFFFFFF, TCNT = 0.
  - pending = 0, `irq` = 0, `led` = 0.
  - Synchronizer flops = 0.
  - RAM contents are not reset.
- Reset is asynchronous. Asserting it mid-count immediately zeros TCNT, TCTRL and `irq`. Deassertion takes effect at the next edge.
- SW register latency: 2 cycles from a `sw` change.

## Configuration
- Macro: `DATA_BUS_TIMER_EN`.
- When defined: the timer registers, pending bit and `irq` exist as described.
- When undefined:
  - Offsets 0x10–0x1C read 0 and ignore writes.
  - `irq` is tied to 0.
  - No counter logic is generated.
  - RAM, LED and SW behaviour is unchanged.

## Structure
- Shared package `bus_map_pkg` holds:
  - the MMIO base 0xFFFFFF00;
  - register offset constants;
  - TCTRL bit-index constants;
  - the TCMP reset value.
- One sub-module, `interval_timer`, covers TCTRL/TCMP/TCNT/pending/irq and its write ports.
- RAM, decode and read mux stay in the top module.

## Test plan
- Write 0xDEADBEEF to 0x00000010, then read 0x00000010 → `mem_din` = 0xDEADBEEF. Read 0x00000012 → same value (low bits ignored).
- Write 0x00005A5A to 0xFFFFFF00 → `led` = 0x5A5A after the edge. With `sw`=0x1234, read 0xFFFFFF04 two cycles later → 0x00001234.
- TCMP=5, TCTRL=0x7 → pending sets on the cycle TCNT=5 and `irq`=1 one cycle later. TCNT restarts from 0. Write 1 to 0xFFFFFF1C → `irq` drops next cycle.
- TCMP=3, TCTRL=0x5 (no reload) → after the match, TCTRL reads 0x4 and TCNT holds 3.
- W1C to TSTAT on the exact match cycle → TSTAT reads 1 afterward.
- Pulse `rst`=0 mid-count → `irq`, TCNT and TCTRL read 0 immediately. Read 0x00100000 (unmapped) → 0.

Source files
------------

// File: rtl/bus_map_pkg.sv
// Address map shared by data_bus_responder and interval_timer:
// MMIO base, register offsets, TCTRL bit positions and the TCMP reset value.
package bus_map_pkg;

    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_FF00;

    localparam logic [7:0]  OFF_LED    = 8'h00;
    localparam logic [7:0]  OFF_SW     = 8'h04;
    localparam logic [7:0]  OFF_TCTRL  = 8'h10;
    localparam logic [7:0]  OFF_TCMP   = 8'h14;
    localparam logic [7:0]  OFF_TCNT   = 8'h18;
    localparam logic [7:0]  OFF_TSTAT  = 8'h1C;

    localparam int          TCTRL_EN     = 0;
    localparam int          TCTRL_RELOAD = 1;
    localparam int          TCTRL_IRQEN  = 2;
    localparam int          TCTRL_WIDTH  = 3;

    localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_t;

    // RAM occupies the bottom of the address space; MMIO is the top 256-byte page.
    function automatic region_t decode_region(input logic [31:0] addr, input int addr_width);
        region_t region;
        region = REGION_NONE;
        if ((addr >> (addr_width + 2)) == 32'd0)
            region = REGION_RAM;
        else if (addr[31:8] == MMIO_BASE[31:8])
            region = REGION_MMIO;
        return region;
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Interval timer behind the MMIO page: TCTRL/TCMP/TCNT, the pending flag and the
// registered interrupt request. Only built when DATA_BUS_TIMER_EN is defined.
module interval_timer
    import bus_map_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_ctrl,
    input  logic                   i_wr_cmp,
    input  logic                   i_wr_cnt,
    input  logic                   i_wr_stat,
    input  logic [31:0]            i_wdata,
    output logic [TCTRL_WIDTH-1:0] o_ctrl,
    output logic [31:0]            o_cmp,
    output logic [31:0]            o_cnt,
    output logic                   o_pending,
    output logic                   o_irq
);

    logic [TCTRL_WIDTH-1:0] r_ctrl;
    logic [31:0]            r_cmp;
    logic [31:0]            r_cnt;
    logic                   r_pending;
    logic                   r_irq;
    logic                   w_match;

    assign w_match = r_ctrl[TCTRL_EN] && (r_cnt == r_cmp);

    // A software write to TCTRL overrides the one-shot self-disable on a match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_ctrl <= '0;
        else if (i_wr_ctrl)
            r_ctrl <= i_wdata[TCTRL_WIDTH-1:0];
        else if (w_match && !r_ctrl[TCTRL_RELOAD])
            r_ctrl[TCTRL_EN] <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cmp <= TCMP_RESET;
        else if (i_wr_cmp)
            r_cmp <= i_wdata;
    end

    // One-shot mode holds the count on the match value; reload restarts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_wr_cnt)
            r_cnt <= i_wdata;
        else if (w_match) begin
            if (r_ctrl[TCTRL_RELOAD])
                r_cnt <= '0;
        end
        else if (r_ctrl[TCTRL_EN])
            r_cnt <= r_cnt + 32'd1;
    end

    // The hardware set takes priority over a simultaneous write-one-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_pending <= 1'b0;
        else if (w_match)
            r_pending <= 1'b1;
        else if (i_wr_stat && i_wdata[0])
            r_pending <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_irq <= 1'b0;
        else
            r_irq <= r_pending & r_ctrl[TCTRL_IRQEN];
    end

    assign o_ctrl    = r_ctrl;
    assign o_cmp     = r_cmp;
    assign o_cnt     = r_cnt;
    assign o_pending = r_pending;
    assign o_irq     = r_irq;

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory responder for the core: word RAM plus an MMIO page (LED, SW, timer).
// Define DATA_BUS_TIMER_EN to build the interval timer and its interrupt request.
module data_bus_responder
    import bus_map_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LED_WIDTH  = 16,
    parameter int SW_WIDTH   = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_ren,
    input  logic                 mem_wen,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_dout,
    output logic [31:0]          mem_din,
    input  logic [SW_WIDTH-1:0]  sw,
    output logic [LED_WIDTH-1:0] led,
    output logic                 irq
);

    logic [31:0]           r_ram [0:(2**ADDR_WIDTH)-1];
    logic [LED_WIDTH-1:0]  r_led;
    logic [SW_WIDTH-1:0]   r_sw_meta;
    logic [SW_WIDTH-1:0]   r_sw_sync;

    region_t               w_region;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [7:0]            w_off;
    logic                  w_mmio_wr;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    assign w_region  = decode_region(mem_addr, ADDR_WIDTH);
    assign w_word    = mem_addr[ADDR_WIDTH+1:2];
    assign w_off     = {mem_addr[7:2], 2'b00};
    assign w_mmio_wr = mem_wen && (w_region == REGION_MMIO);
    assign w_unused  = ^{mem_addr[1:0], mem_dout};

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_wen && (w_region == REGION_RAM))
            r_ram[w_word] <= mem_dout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_led <= '0;
        else if (w_mmio_wr && (w_off == OFF_LED))
            r_led <= mem_dout[LED_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end
        else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

`ifdef DATA_BUS_TIMER_EN
    logic [TCTRL_WIDTH-1:0] w_tctrl;
    logic [31:0]            w_tcmp;
    logic [31:0]            w_tcnt;
    logic                   w_tpending;

    interval_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_ctrl (w_mmio_wr && (w_off == OFF_TCTRL)),
        .i_wr_cmp  (w_mmio_wr && (w_off == OFF_TCMP)),
        .i_wr_cnt  (w_mmio_wr && (w_off == OFF_TCNT)),
        .i_wr_stat (w_mmio_wr && (w_off == OFF_TSTAT)),
        .i_wdata   (mem_dout),
        .o_ctrl    (w_tctrl),
        .o_cmp     (w_tcmp),
        .o_cnt     (w_tcnt),
        .o_pending (w_tpending),
        .o_irq     (irq)
    );
`else
    assign irq = 1'b0;
`endif

    // Reads see the state before any same-cycle write commits.
    always_comb begin
        w_rdata = '0;
        if (mem_ren) begin
            case (w_region)
                REGION_RAM:
                    w_rdata = r_ram[w_word];
                REGION_MMIO: begin
                    case (w_off)
                        OFF_LED:   w_rdata[LED_WIDTH-1:0] = r_led;
                        OFF_SW:    w_rdata[SW_WIDTH-1:0]  = r_sw_sync;
`ifdef DATA_BUS_TIMER_EN
                        OFF_TCTRL: w_rdata[TCTRL_WIDTH-1:0] = w_tctrl;
                        OFF_TCMP:  w_rdata = w_tcmp;
                        OFF_TCNT:  w_rdata = w_tcnt;
                        OFF_TSTAT: w_rdata[0] = w_tpending;
`endif
                        default:   w_rdata = '0;
                    endcase
                end
                default:
                    w_rdata = '0;
            endcase
        end
    end

    assign mem_din = w_rdata;
    assign led     = r_led;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: directed scenarios then random traffic,
// checked against a behavioural model of the memory map and timer.
module tb_data_bus_responder;

    localparam int ADDR_WIDTH = 10;
    localparam int LED_WIDTH  = 16;
    localparam int SW_WIDTH   = 16;
`ifdef DATA_BUS_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 memRen = 1'b0;
    logic                 memWen = 1'b0;
    logic [31:0]          memAddr = 32'h0;
    logic [31:0]          memDout = 32'h0;
    logic [31:0]          memDin;
    logic [SW_WIDTH-1:0]  sw = '0;
    logic [LED_WIDTH-1:0] led;
    logic                 irq;

    always #5 clk = ~clk;

    data_bus_responder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LED_WIDTH  (LED_WIDTH),
        .SW_WIDTH   (SW_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_ren  (memRen),
        .mem_wen  (memWen),
        .mem_addr (memAddr),
        .mem_dout (memDout),
        .mem_din  (memDin),
        .sw       (sw),
        .led      (led),
        .irq      (irq)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [15:0] led;
        logic        irq;
        logic [31:0] addr;
    } expect_t;

    expect_t scoreboard[$];
    expect_t monExp;
    int      checks = 0;
    int      errors = 0;

    // Behavioural model of the visible state.
    logic [31:0] mRam [int];
    logic [15:0] mLed, mSwA, mSwB;
    logic [2:0]  mCtrl;
    logic [31:0] mCmp, mCnt;
    logic        mPending, mIrq;

    function automatic void modelReset();
        mLed     = 16'h0;
        mSwA     = 16'h0;
        mSwB     = 16'h0;
        mCtrl    = 3'h0;
        mCmp     = TIMER_ON ? 32'hFFFF_FFFF : 32'h0;
        mCnt     = 32'h0;
        mPending = 1'b0;
        mIrq     = 1'b0;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        logic [31:0] off;
        if (addr < 32'h0000_1000)
            return mRam.exists(int'(addr >> 2)) ? mRam[int'(addr >> 2)] : 32'h0;
        if (addr < 32'hFFFF_FF00)
            return 32'h0;
        off = addr & 32'hFC;
        case (off)
            32'h00: return {16'h0, mLed};
            32'h04: return {16'h0, mSwB};
            32'h10: return TIMER_ON ? {29'h0, mCtrl} : 32'h0;
            32'h14: return TIMER_ON ? mCmp : 32'h0;
            32'h18: return TIMER_ON ? mCnt : 32'h0;
            32'h1C: return TIMER_ON ? {31'h0, mPending} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge: timer rules first, then software writes override, then the match sets pending.
    function automatic void modelStep(input logic wen, input logic [31:0] addr,
                                      input logic [31:0] dout, input logic [15:0] swNow);
        logic [2:0]  nCtrl;
        logic [31:0] nCnt;
        logic        nPending;
        logic        hit;
        logic [31:0] off;
        nCtrl    = mCtrl;
        nCnt     = mCnt;
        nPending = mPending;
        hit      = TIMER_ON && mCtrl[0] && (mCnt == mCmp);
        if (TIMER_ON && mCtrl[0]) begin
            if (hit) begin
                if (mCtrl[1]) nCnt = 32'h0;
                else          nCtrl[0] = 1'b0;
            end
            else
                nCnt = mCnt + 32'd1;
        end
        if (wen) begin
            if (addr < 32'h0000_1000)
                mRam[int'(addr >> 2)] = dout;
            else if (addr >= 32'hFFFF_FF00) begin
                off = addr & 32'hFC;
                if (off == 32'h00)
                    mLed = dout[15:0];
                else if (TIMER_ON) begin
                    case (off)
                        32'h10: nCtrl = dout[2:0];
                        32'h14: mCmp  = dout;
                        32'h18: nCnt  = dout;
                        32'h1C: if (dout[0]) nPending = 1'b0;
                        default: ;
                    endcase
                end
            end
        end
        if (hit) nPending = 1'b1;
        mIrq     = TIMER_ON && mPending && mCtrl[2];
        mCtrl    = nCtrl;
        mCnt     = nCnt;
        mPending = nPending;
        mSwB     = mSwA;
        mSwA     = swNow;
    endfunction

    task automatic applyStimulus(input logic ren, input logic wen,
                                 input logic [31:0] addr, input logic [31:0] dout);
        expect_t e;
        memRen  = ren;
        memWen  = wen;
        memAddr = addr;
        memDout = dout;
        if (ren) begin
            e.rdata = modelRead(addr);
            e.led   = mLed;
            e.irq   = mIrq;
            e.addr  = addr;
            scoreboard.push_back(e);
        end
        @(posedge clk);
        if (!rst) modelReset();
        else      modelStep(wen, addr, dout, sw);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected, input logic [31:0] addr);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s @addr=%h: got %h, expected %h (t=%0t)",
                     name, addr, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (memRen) begin
            if (scoreboard.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_empty: got a read with no expectation queued (t=%0t)", $time);
            end
            else begin
                monExp = scoreboard.pop_front();
                checkOutput("mem_din", memDin, monExp.rdata, monExp.addr);
                checkOutput("led", {16'h0, led}, {16'h0, monExp.led}, monExp.addr);
                checkOutput("irq", {31'h0, irq}, {31'h0, monExp.irq}, monExp.addr);
            end
        end
    end

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b0, 1'b1, addr, data);
    endtask

    task automatic busRead(input logic [31:0] addr);
        applyStimulus(1'b1, 1'b0, addr, 32'h0);
    endtask

    logic [31:0] ramPool [16];
    logic [31:0] mmioPool [9];
    logic [31:0] unmappedPool [4];

    initial begin
        logic [31:0] addr;
        logic [31:0] dout;
        logic        ren;
        logic        wen;
        int          kind;

        modelReset();
        mmioPool     = '{32'hFFFF_FF00, 32'hFFFF_FF04, 32'hFFFF_FF08, 32'hFFFF_FF10, 32'hFFFF_FF14,
                         32'hFFFF_FF18, 32'hFFFF_FF1C, 32'hFFFF_FF20, 32'hFFFF_FFFC};
        unmappedPool = '{32'h0010_0000, 32'h8000_0000, 32'hFFFF_FE00, 32'h0000_1000};
        @(posedge clk);
        #1;

        // Reset values, read while reset is held.
        busRead(32'hFFFF_FF18);
        busRead(32'hFFFF_FF14);
        busRead(32'hFFFF_FF10);
        busRead(32'hFFFF_FF00);
        busRead(32'hFFFF_FF1C);
        rst = 1'b1;

        // RAM write/read, low address bits ignored.
        busWrite(32'h0000_0010, 32'hDEAD_BEEF);
        busRead(32'h0000_0010);
        busRead(32'h0000_0012);
        busRead(32'h0000_0FFC);

        // LED and synchronised switches.
        busWrite(32'hFFFF_FF00, 32'h0000_5A5A);
        sw = 16'h1234;
        busRead(32'hFFFF_FF04);
        busRead(32'hFFFF_FF04);
        busRead(32'hFFFF_FF04);

        // Auto-reload with interrupt, then clear.
        busWrite(32'hFFFF_FF14, 32'd5);
        busWrite(32'hFFFF_FF10, 32'h7);
        for (int i = 0; i < 10; i++) busRead(32'hFFFF_FF18);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FF1C, 32'h1);
        for (int i = 0; i < 3; i++) busRead(32'hFFFF_FF1C);

        // One-shot: enable self-clears and the count holds on the match value.
        busWrite(32'hFFFF_FF10, 32'h0);
        busWrite(32'hFFFF_FF18, 32'h0);
        busWrite(32'hFFFF_FF1C, 32'h1);
        busWrite(32'hFFFF_FF14, 32'd3);
        busWrite(32'hFFFF_FF10, 32'h5);
        for (int i = 0; i < 4; i++) begin
            busRead(32'hFFFF_FF10);
            busRead(32'hFFFF_FF18);
        end

        // Clear request landing on the exact match cycle.
        busWrite(32'hFFFF_FF10, 32'h0);
        busWrite(32'hFFFF_FF1C, 32'h1);
        busWrite(32'hFFFF_FF18, 32'h0);
        busWrite(32'hFFFF_FF14, 32'd4);
        busWrite(32'hFFFF_FF10, 32'h1);
        for (int i = 0; i < 20 && !(mCtrl[0] && mCnt == mCmp); i++) busRead(32'hFFFF_FF18);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FF1C, 32'h1);
        busRead(32'hFFFF_FF1C);
        busRead(32'hFFFF_FF1C);

        // Asynchronous reset in the middle of counting.
        busWrite(32'hFFFF_FF1C, 32'h1);
        busWrite(32'hFFFF_FF14, 32'd2);
        busWrite(32'hFFFF_FF10, 32'h7);
        for (int i = 0; i < 6; i++) busRead(32'hFFFF_FF18);
        rst = 1'b0;
        modelReset();
        busRead(32'hFFFF_FF18);
        busRead(32'hFFFF_FF10);
        busRead(32'h0010_0000);
        rst = 1'b1;
        busRead(32'hFFFF_FF18);
        busRead(32'h0000_0010);

        // Random traffic over RAM, MMIO and unmapped space.
        for (int i = 0; i < 16; i++) begin
            ramPool[i] = 32'($urandom_range(0, 1023)) << 2;
            busWrite(ramPool[i], $urandom);
        end
        for (int i = 0; i < 600; i++) begin
            kind = int'($urandom_range(0, 3));
            if (kind <= 1)      addr = ramPool[$urandom_range(0, 15)] | 32'($urandom_range(0, 3));
            else if (kind == 2) addr = mmioPool[$urandom_range(0, 8)] | 32'($urandom_range(0, 3));
            else                addr = unmappedPool[$urandom_range(0, 3)];
            ren  = ($urandom_range(0, 3) != 0);
            wen  = ($urandom_range(0, 2) == 0);
            dout = $urandom;
            if ((addr & 32'hFFFF_FFFC) == 32'hFFFF_FF14 || (addr & 32'hFFFF_FFFC) == 32'hFFFF_FF18)
                dout = 32'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
            applyStimulus(ren, wen, addr, dout);
        end

        memRen = 1'b0;
        memWen = 1'b0;
        @(negedge clk);
        checks++;
        if (scoreboard.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", scoreboard.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
